io_sequencer: RTL

IO_SEQUENCER -- requirements
Module: io_sequencer

---
 rtl/bbtron_pkg.sv | 14 +
 rtl/io_sequencer_edge_detect.sv | 27 ++
 rtl/io_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bbtron_pkg.sv
// Shared types and constants for the bbtron IO sequencing logic.
package bbtron_pkg;

  localparam int IO_STATE_W = 3;

  typedef enum logic [IO_STATE_W-1:0] {
    IDLE         = 3'd0,
    WAIT_RELEASE = 3'd1,
    WAIT_PRESS   = 3'd2,
    CAPTURE      = 3'd3,
    OUT_HOLD     = 3'd4
  } io_state_e;

endpackage

// File: rtl/io_sequencer_edge_detect.sv
// Rising-edge detector for the debounced enter button.
// Previous value resets to 1 so a button held through reset is not a rise.
module edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = in & ~prev_q;

endmodule

// File: rtl/io_sequencer.sv
// IN/OUT instruction sequencer: stalls the core for switch entry and display.
// Optional IN wait timeout is enabled by defining IO_TIMEOUT_EN.
module io_sequencer
  import bbtron_pkg::*;
#(
  parameter int HOLD_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cu_inReq,
  input  logic        cu_outReq,
  input  logic        DB_Out,
  input  logic [15:0] switches,
  input  logic [31:0] aluOut,
  output logic        hlt,
  output logic [15:0] inData,
  output logic        inValid,
  output logic [31:0] dispValue,
  output logic        negative,
  output logic        timeout
);

  localparam int HOLD_W =
    (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD =
    (HOLD_CYCLES > 0) ? HOLD_W'(HOLD_CYCLES - 1) : '0;

  io_state_e         state_q;
  io_state_e         state_d;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;
  logic [15:0]       in_data_q;
  logic [15:0]       in_data_d;
  logic [31:0]       disp_q;
  logic [31:0]       disp_d;
  logic              db_rise;
  logic              to_fire;
  logic              in_wait;

  edge_detect u_edge (
    .clock (clock),
    .reset (reset),
    .in    (DB_Out),
    .rise  (db_rise)
  );

  assign in_wait = (state_q == WAIT_RELEASE) ||
                   (state_q == WAIT_PRESS);

`ifdef IO_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic [TO_W-1:0] to_cnt_d;
  logic            timeout_q;
  logic            timeout_d;
  logic            to_hit;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // A real press in WAIT_PRESS wins over a coincident expiry.
  assign to_fire = in_wait && to_hit &&
                   !((state_q == WAIT_PRESS) && db_rise);

  always_comb begin
    to_cnt_d  = '0;
    timeout_d = timeout_q | to_fire;
    if (in_wait && !to_fire) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign to_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    in_data_d = in_data_q;
    disp_d    = disp_q;
    hlt       = 1'b0;
    inValid   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cu_inReq) begin
          hlt     = 1'b1;
          state_d = WAIT_RELEASE;
        end else if (cu_outReq) begin
          disp_d = aluOut;
          if (HOLD_CYCLES > 0) begin
            hlt     = 1'b1;
            hold_d  = HOLD_LOAD;
            state_d = OUT_HOLD;
          end
        end
      end
      WAIT_RELEASE: begin
        hlt = 1'b1;
        if (to_fire) begin
          in_data_d = '0;
          state_d   = CAPTURE;
        end else if (!DB_Out) begin
          state_d = WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        hlt = 1'b1;
        if (db_rise) begin
          in_data_d = switches;
          state_d   = CAPTURE;
        end else if (to_fire) begin
          in_data_d = '0;
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        inValid = 1'b1;
        state_d = IDLE;
      end
      OUT_HOLD: begin
        if (hold_q != '0) begin
          hlt    = 1'b1;
          hold_d = hold_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      in_data_q <= '0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      in_data_q <= in_data_d;
      disp_q    <= disp_d;
    end
  end

  assign inData    = in_data_q;
  assign dispValue = disp_q;
  assign negative  = disp_q[31];

endmodule
